// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StWaitLow,
    StWaitHigh,
    StDelay,
    StGap
  } seq_state_e;

  // Command word layout: [10]=delay, [9]=power-on, [8]=D/C, [7:0]=data or delay count.
  localparam int unsigned CMD_W   = 11;
  localparam int unsigned DIN_W   = 10;
  localparam int unsigned DLY_BIT = 10;
  localparam int unsigned PWR_BIT = 9;
  localparam int unsigned DC_BIT  = 8;

  // Cycles WAIT_LOW tolerates CS staying high before the byte is abandoned.
  localparam int unsigned WAIT_LOW_TIMEOUT = 4;

  // Driver payload: {power-on, D/C, data}.
  function automatic logic [DIN_W-1:0] cmd_payload(input logic [CMD_W-1:0] cmd);
    return cmd[DIN_W-1:0];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with push, pop, flush and an exact occupancy count.
module cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointer and count next-state; flush clears everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_cmd_seq.sv
// Command sequencer: queues CPU display commands and feeds them to the SPI byte
// driver one at a time, tracking transfers via chip-select and running delays.
module spi_cmd_seq
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned DELAY_TICK = 62500,
  parameter int unsigned GUARD      = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr_en,
  input  logic [10:0]      wr_data,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic [AW:0]      count,
  output logic             full,
  output logic             busy,
  output logic             overflow,
  output logic             spi_start,
  output logic [9:0]       spi_din,
  input  logic             spi_cs_
);

  localparam int unsigned TW = (DELAY_TICK > 1) ? $clog2(DELAY_TICK) : 1;
  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

  seq_state_e        state_q, state_d;
  logic              start_q, start_d;
  logic [DIN_W-1:0]  din_q, din_d;
  logic [2:0]        wl_q, wl_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [7:0]        unit_q, unit_d;
  logic [7:0]        dly_q, dly_d;
  logic              ovf_q, ovf_d;

  logic              pop;
  logic              fifo_empty;
  logic [CMD_W-1:0]  head;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (CMD_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  assign spi_start = start_q;
  assign spi_din   = din_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != StIdle) || (count != '0);

  // Sticky overflow: a dropped write (not one squashed by flush) beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (wr_en && full && !flush) ovf_d = 1'b1;
  end

  // Sequencer next-state: issue, wait on CS, delay and guard gap.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    din_d   = din_q;
    wl_d    = wl_q;
    gap_d   = gap_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
    dly_d   = dly_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only issue while the driver is idle so a pulse never lands mid-transfer.
        if (!fifo_empty && spi_cs_) begin
          pop = 1'b1;
          if (head[DLY_BIT]) begin
            if (head[7:0] == 8'd0) begin
              state_d = StGap;
              gap_d   = '0;
            end else begin
              state_d = StDelay;
              tick_d  = '0;
              unit_d  = '0;
              dly_d   = head[7:0];
            end
          end else begin
            start_d = 1'b1;
            din_d   = cmd_payload(head);
            if (head[PWR_BIT]) begin
              // Power switching never drops CS, so skip the transfer wait.
              state_d = StGap;
              gap_d   = '0;
            end else begin
              state_d = StWaitLow;
              wl_d    = '0;
            end
          end
        end
      end
      StWaitLow: begin
        if (!spi_cs_) begin
          state_d = StWaitHigh;
        end else if (wl_q == 3'(WAIT_LOW_TIMEOUT - 1)) begin
          // Byte considered lost; move on without retry.
          state_d = StGap;
          gap_d   = '0;
        end else begin
          wl_d = wl_q + 3'd1;
        end
      end
      StWaitHigh: begin
        if (spi_cs_) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StDelay: begin
        if (tick_q == TW'(DELAY_TICK - 1)) begin
          tick_d = '0;
          if (unit_q == dly_q - 8'd1) begin
            state_d = StGap;
            gap_d   = '0;
          end else begin
            unit_d = unit_q + 8'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GW'(GUARD - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and flag registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      din_q   <= '0;
      wl_q    <= '0;
      gap_q   <= '0;
      tick_q  <= '0;
      unit_q  <= '0;
      dly_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      din_q   <= din_d;
      wl_q    <= wl_d;
      gap_q   <= gap_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      dly_q   <= dly_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Self-checking bench for spi_cmd_seq with a scoreboard of expected driver payloads.
module tb_spi_cmd_seq;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int          TICK  = 20;
  localparam int          GUARD = 2;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          wr_en = 1'b0;
  logic [10:0]   wr_data = '0;
  logic          flush = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   count;
  logic          full, busy, overflow, spi_start;
  logic [9:0]    spi_din;
  logic          cs_n;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int hold = 450;
  bit drv_dead = 1'b0;
  int cs_cnt;
  logic [9:0] exp_q[$];
  logic [9:0] exp_din;
  int pulse_cyc[$];
  int last_rise = -1000;
  logic cs_prev = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_cmd_seq #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .DELAY_TICK (TICK),
    .GUARD      (GUARD)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow),
    .spi_start (spi_start),
    .spi_din   (spi_din),
    .spi_cs_   (cs_n)
  );

  // Driver model: lowers CS the edge after a data start pulse, for 'hold' cycles.
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cs_n   <= 1'b1;
      cs_cnt <= 0;
    end else if (!cs_n) begin
      if (cs_cnt <= 1) cs_n <= 1'b1;
      cs_cnt <= cs_cnt - 1;
    end else if (spi_start && !spi_din[9] && !drv_dead) begin
      cs_n   <= 1'b0;
      cs_cnt <= hold;
    end
  end

  // Monitor: pops the scoreboard on every start pulse.
  always @(negedge clk) begin
    if (reset_) begin
      if (cs_n && !cs_prev) last_rise = cyc;
      if (spi_start) begin
        pulse_cyc.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pulse_unexpected: got din=%h, no pulse expected", spi_din);
        end else begin
          exp_din = exp_q.pop_front();
          if (spi_din !== exp_din) begin
            n_fail++;
            $display("FAIL pulse_din: got %h, required %h", spi_din, exp_din);
          end
        end
        n_cmp++;
        if (cs_n !== 1'b1) begin
          n_fail++;
          $display("FAIL start_while_cs_low: cs=%b, required 1", cs_n);
        end
        n_cmp++;
        if (cyc - last_rise < GUARD + 1) begin
          n_fail++;
          $display("FAIL guard_gap: %0d cycles after CS rise, required >= %0d",
                   cyc - last_rise, GUARD + 1);
        end
      end
    end
    cs_prev = cs_n;
  end

  task automatic do_write(input logic [10:0] d, input bit issued);
    wr_en   = 1'b1;
    wr_data = d;
    if (issued) exp_q.push_back(d[9:0]);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, budget);
    end
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (pulse_cyc.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (pulse_cyc.size() < n) begin
      n_fail++;
      $display("FAIL %s_pulse_wait: got %0d pulses, required %0d", tag, pulse_cyc.size(), n);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({spi_start, spi_din, count, full, busy, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%b din=%h count=%0d full=%b busy=%b ovf=%b, required all 0",
               spi_start, spi_din, count, full, busy, overflow);
    end
    reset_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_data;
    pulse_cyc.delete();
    hold = 450;
    do_write(11'h1AF, 1'b1);
    do_write(11'h0A0, 1'b1);
    do_write(11'h0FF, 1'b1);
    n_cmp++;
    if (count !== 5'd2) begin
      n_fail++;
      $display("FAIL data_count: got %0d, required 2", count);
    end
    wait_idle(3000, "data");
    n_cmp++;
    if (pulse_cyc.size() != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL data_pulses: got %0d pulses, %0d left, required 3 and 0",
               pulse_cyc.size(), exp_q.size());
    end
  endtask

  task automatic test_delay;
    hold = 5;
    // Power-on, 3-unit delay, data.
    pulse_cyc.delete();
    do_write(11'h200, 1'b1);
    do_write(11'h403, 1'b0);
    do_write(11'h0AE, 1'b1);
    wait_idle(500, "delay3");
    n_cmp++;
    if (pulse_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL delay3_pulses: got %0d, required 2", pulse_cyc.size());
    end else if (pulse_cyc[1] - pulse_cyc[0] != 3 * TICK + 6) begin
      n_fail++;
      $display("FAIL delay3_spacing: got %0d cycles, required %0d",
               pulse_cyc[1] - pulse_cyc[0], 3 * TICK + 6);
    end
    // Zero-length delay only costs IDLE plus the guard gap.
    pulse_cyc.delete();
    do_write(11'h200, 1'b1);
    do_write(11'h400, 1'b0);
    do_write(11'h0AE, 1'b1);
    wait_idle(500, "delay0");
    n_cmp++;
    if (pulse_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL delay0_pulses: got %0d, required 2", pulse_cyc.size());
    end else if (pulse_cyc[1] - pulse_cyc[0] != 6) begin
      n_fail++;
      $display("FAIL delay0_spacing: got %0d cycles, required 6", pulse_cyc[1] - pulse_cyc[0]);
    end
  endtask

  task automatic test_overflow;
    pulse_cyc.delete();
    hold = 40;
    do_write(11'h101, 1'b1);
    wait_pulses(1, 20, "ovf");
    for (int i = 0; i < 17; i++) do_write(11'(11'h010 + i), i < 16);
    n_cmp++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: count=%0d full=%b ovf=%b, required 16 1 1", count, full, overflow);
    end
    // Set and clear together: set wins.
    wr_en   = 1'b1;
    wr_data = 11'h7FF;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b, required 1", overflow);
    end
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, required 0", overflow);
    end
    wait_idle(5000, "ovf");
    n_cmp++;
    if (pulse_cyc.size() != 17 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_pulses: got %0d pulses, %0d left, required 17 and 0",
               pulse_cyc.size(), exp_q.size());
    end
  endtask

  task automatic test_flush;
    int i;
    pulse_cyc.delete();
    hold = 200;
    do_write(11'h1F0, 1'b1);
    wait_pulses(1, 20, "flush");
    for (int k = 0; k < 5; k++) do_write(11'(11'h0B0 + k), 1'b0);
    i = 0;
    while (cs_n && i < 20) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    n_cmp++;
    if (count !== 5'd5) begin
      n_fail++;
      $display("FAIL flush_pre_count: got %0d, required 5", count);
    end
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 11'h0EE;
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || overflow !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: count=%0d ovf=%b busy=%b, required 0 0 1", count, overflow, busy);
    end
    wait_idle(500, "flush");
    n_cmp++;
    if (pulse_cyc.size() != 1 || spi_din !== 10'h1F0) begin
      n_fail++;
      $display("FAIL flush_pulses: got %0d pulses din=%h, required 1 and 1f0",
               pulse_cyc.size(), spi_din);
    end
  endtask

  task automatic test_reset_mid;
    // Mid-WAIT_HIGH with two entries still queued.
    hold = 200;
    pulse_cyc.delete();
    do_write(11'h155, 1'b1);
    do_write(11'h0AA, 1'b1);
    do_write(11'h0BB, 1'b1);
    wait_pulses(1, 20, "rst_wh");
    repeat (10) @(negedge clk);
    reset_ = 1'b0;
    #1;
    n_cmp++;
    if (spi_start !== 1'b0 || spi_din !== 10'h0 || count !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_high: start=%b din=%h count=%0d busy=%b, required 0 0 0 0",
               spi_start, spi_din, count, busy);
    end
    exp_q.delete();
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    hold = 5;
    do_write(11'h0C3, 1'b1);
    wait_idle(100, "rst_after");
    // Mid-DELAY with one entry queued behind it.
    do_write(11'h40A, 1'b0);
    do_write(11'h0DD, 1'b1);
    repeat (50) @(negedge clk);
    reset_ = 1'b0;
    #1;
    n_cmp++;
    if (spi_start !== 1'b0 || spi_din !== 10'h0 || count !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_delay: start=%b din=%h count=%0d busy=%b, required 0 0 0 0",
               spi_start, spi_din, count, busy);
    end
    exp_q.delete();
    @(negedge clk);
    reset_ = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_release: busy=%b count=%0d, required 0 0", busy, count);
    end
  endtask

  task automatic test_timeout;
    pulse_cyc.delete();
    drv_dead = 1'b1;
    do_write(11'h011, 1'b1);
    do_write(11'h122, 1'b1);
    wait_idle(100, "timeout");
    n_cmp++;
    if (pulse_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL timeout_pulses: got %0d, required 2", pulse_cyc.size());
    end else if (pulse_cyc[1] - pulse_cyc[0] != 7) begin
      n_fail++;
      $display("FAIL timeout_spacing: got %0d cycles, required 7", pulse_cyc[1] - pulse_cyc[0]);
    end
    drv_dead = 1'b0;
  endtask

  initial begin
    test_reset();
    test_data();
    test_delay();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_timeout();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
